// File: rtl/pwm_pkg.sv
// Shared definitions for the H-bridge PWM generator: state encodings,
// ratio width and the last value of the period counter.
package pwm_pkg;

   localparam int unsigned RATIO_W = 8;
   localparam int unsigned STATE_W = 2;

   // Plain constants rather than an enum so older flows can reuse the encoding.
   localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
   localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
   localparam logic [STATE_W-1:0] ST_DEAD = 2'd2;

   // Period counter runs 0..254, so one PWM period is 255 ticks.
   localparam logic [RATIO_W-1:0] PWM_PERIOD_MAX = 8'd254;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider producing a one-cycle tick every PRESCALE clocks while run=1.
// Held at zero whenever run is low, so every run starts from a full interval.
module pwm_prescaler #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int unsigned   PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] TERM = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;

   // Next count: clear when stopped or at terminal count, else increment.
   always_comb begin
      pre_d = pre_q;
      if (!run || (pre_q == TERM)) begin
         pre_d = '0;
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   assign tick = run && (pre_q == TERM);

   // Count register with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/pwm_generator.sv
// PWM / direction driver for one motor H-bridge. New ratios take effect only
// at period boundaries; a direction reversal inserts DEADTIME_PERIODS periods
// with pwm_out forced low before the new direction and ratio are applied.
//
// Request handshake (4-phase): upstream raises pwm_update with ratio and
// direction and holds it; the request is captured once and later applied, at
// which point pwm_done rises (only while pwm_update is high). pwm_done stays
// high until pwm_update is sampled low, then falls on the following edge. A new
// request is accepted only after pwm_done has returned low.
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int unsigned PRESCALE         = 4,
   parameter int unsigned DEADTIME_PERIODS = 2
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pwm_enable,
   input  logic               pwm_update,
   input  logic [RATIO_W-1:0] pwm_ratio,
   input  logic               pwm_direction,
   output logic               pwm_done,
   output logic               pwm_out,
   output logic               dir_out,
   output logic [7:0]         debug_signals
);

   localparam int unsigned   DW        = (DEADTIME_PERIODS > 1) ? $clog2(DEADTIME_PERIODS) : 1;
   localparam logic [DW-1:0] DEAD_TERM = DW'(DEADTIME_PERIODS - 1);

   logic [STATE_W-1:0] state_q,    state_d;
   logic [RATIO_W-1:0] cnt_q,      cnt_d;
   logic [RATIO_W-1:0] duty_q,     duty_d;
   logic [RATIO_W-1:0] ratio_q,    ratio_d;
   logic               req_dir_q,  req_dir_d;
   logic               dir_out_q,  dir_out_d;
   logic               pending_q,  pending_d;
   logic               done_q,     done_d;
   logic               pwm_out_q,  pwm_out_d;
   logic [DW-1:0]      dead_cnt_q, dead_cnt_d;

   logic presc_run;
   logic tick;
   logic boundary;

   // Prescaler runs only while active and enabled, so it restarts from zero.
   assign presc_run = (state_q != ST_IDLE) && pwm_enable;

   pwm_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clock (clock),
      .reset (reset),
      .run   (presc_run),
      .tick  (tick)
   );

   assign boundary = tick && (cnt_q == PWM_PERIOD_MAX);

   // Next-state logic: disable first, then boundary apply, then capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      duty_d     = duty_q;
      ratio_d    = ratio_q;
      req_dir_d  = req_dir_q;
      dir_out_d  = dir_out_q;
      pending_d  = pending_q;
      done_d     = done_q;
      dead_cnt_d = dead_cnt_q;

      if (!pwm_enable) begin
         state_d    = ST_IDLE;
         cnt_d      = '0;
         duty_d     = '0;
         pending_d  = 1'b0;
         done_d     = 1'b0;
         dead_cnt_d = '0;
      end else begin
         if (!pwm_update) begin
            done_d = 1'b0;
         end

         if ((state_q != ST_IDLE) && tick) begin
            cnt_d = boundary ? '0 : cnt_q + 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               cnt_d      = '0;
               duty_d     = '0;
               dead_cnt_d = '0;
               state_d    = ST_RUN;
            end
            ST_RUN: begin
               if (boundary && pending_q) begin
                  if (req_dir_q == dir_out_q) begin
                     duty_d    = ratio_q;
                     pending_d = 1'b0;
                     done_d    = pwm_update;
                  end else begin
                     state_d    = ST_DEAD;
                     dead_cnt_d = '0;
                  end
               end
            end
            ST_DEAD: begin
               if (boundary) begin
                  if (dead_cnt_q == DEAD_TERM) begin
                     dir_out_d = req_dir_q;
                     duty_d    = ratio_q;
                     pending_d = 1'b0;
                     done_d    = pwm_update;
                     state_d   = ST_RUN;
                  end else begin
                     dead_cnt_d = dead_cnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         // Capture needs pending_q low, so it can never coincide with an apply.
         if (pwm_update && !done_q && !pending_q && (state_q != ST_IDLE)) begin
            ratio_d   = pwm_ratio;
            req_dir_d = pwm_direction;
            pending_d = 1'b1;
         end
      end

      pwm_out_d = (state_d == ST_RUN) && (cnt_d < duty_d);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         duty_q     <= '0;
         ratio_q    <= '0;
         req_dir_q  <= 1'b0;
         dir_out_q  <= 1'b0;
         pending_q  <= 1'b0;
         done_q     <= 1'b0;
         pwm_out_q  <= 1'b0;
         dead_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         duty_q     <= duty_d;
         ratio_q    <= ratio_d;
         req_dir_q  <= req_dir_d;
         dir_out_q  <= dir_out_d;
         pending_q  <= pending_d;
         done_q     <= done_d;
         pwm_out_q  <= pwm_out_d;
         dead_cnt_q <= dead_cnt_d;
      end
   end

   assign pwm_done      = done_q;
   assign pwm_out       = pwm_out_q;
   assign dir_out       = dir_out_q;
   assign debug_signals = {4'b0000, pending_q, (state_q == ST_DEAD), state_q};

endmodule
